// File: rtl/rot_position_counter.sv
// Rotary encoder front end: synchronise and debounce the quadrature pins, decode
// detents with direction, and keep a WIDTH-bit position with wrap or saturate limits.
module rot_position_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ROT_A,
    input  logic             ROT_B,
    input  logic             enable,
    input  logic             clear,
    input  logic             wrap_mode,
    input  logic [1:0]       step_sel,
    output logic [WIDTH-1:0] position,
    output logic             rot_event,
    output logic             rot_dir,
    output logic             limit_hit
);
    localparam int unsigned   CW      = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int unsigned   EW      = WIDTH + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);
    localparam logic [EW-1:0] MAX_EXT = EW'(MAX_VAL);
    localparam logic [EW-1:0] MOD_EXT = EW'(MAX_VAL + 1);

    logic [1:0]       r_s1;
    logic [1:0]       r_s2;
    logic [1:0]       r_cand;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_ab_stable;
    logic             r_q1;
    logic             r_q1_d;
    logic             r_q2;

    logic             w_rise;
    logic [EW-1:0]    w_pos_ext;
    logic [EW-1:0]    w_step;
    logic [EW-1:0]    w_sum;
    logic [WIDTH-1:0] w_pos_nxt;
    logic             w_lim_nxt;

    // Two-flop synchroniser for the asynchronous pin pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 2'b00;
            r_s2 <= 2'b00;
        end else begin
            r_s1 <= {ROT_A, ROT_B};
            r_s2 <= r_s1;
        end
    end

    // A pair is accepted only after it has stayed unchanged for DEBOUNCE cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand      <= 2'b00;
            r_cnt       <= '0;
            r_ab_stable <= 2'b00;
        end else if (r_s2 != r_cand) begin
            r_cand <= r_s2;
            r_cnt  <= '0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_ab_stable <= r_cand;
        end
    end

    // q1 marks the 11/00 half of a detent, q2 remembers which phase led into it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q1   <= 1'b0;
            r_q2   <= 1'b0;
            r_q1_d <= 1'b0;
        end else begin
            r_q1_d <= r_q1;
            case (r_ab_stable)
                2'b11:   r_q1 <= 1'b1;
                2'b00:   r_q1 <= 1'b0;
                2'b01:   r_q2 <= 1'b1;
                2'b10:   r_q2 <= 1'b0;
                default: r_q1 <= r_q1;
            endcase
        end
    end

    assign w_rise = r_q1 & ~r_q1_d;

    // Next position: clear first, then enabled events with wrap/saturate handling
    always_comb begin
        w_pos_ext = {1'b0, position};
        w_step    = EW'(1) << step_sel;
        w_sum     = w_pos_ext + w_step;
        w_pos_nxt = position;
        w_lim_nxt = 1'b0;
        if (clear) begin
            w_pos_nxt = '0;
        end else if (w_rise && enable) begin
            if (!r_q2) begin
                if (w_sum > MAX_EXT) begin
                    w_lim_nxt = 1'b1;
                    w_pos_nxt = wrap_mode ? WIDTH'(w_sum - MOD_EXT) : WIDTH'(MAX_EXT);
                end else begin
                    w_pos_nxt = WIDTH'(w_sum);
                end
            end else begin
                if (w_pos_ext < w_step) begin
                    w_lim_nxt = 1'b1;
                    w_pos_nxt = wrap_mode ? WIDTH'(w_pos_ext + MOD_EXT - w_step) : '0;
                end else begin
                    w_pos_nxt = WIDTH'(w_pos_ext - w_step);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            position  <= '0;
            rot_event <= 1'b0;
            rot_dir   <= 1'b0;
            limit_hit <= 1'b0;
        end else begin
            position  <= w_pos_nxt;
            rot_event <= w_rise;
            limit_hit <= w_lim_nxt;
            if (w_rise) begin
                rot_dir <= r_q2;
            end
        end
    end

endmodule

// File: tb/tb_rot_position_counter.sv
// Scoreboard bench for rot_position_counter: detent stimulus pushes the expected
// event (cycle, direction, position, limit) and a negedge monitor checks each pulse.
module tb_rot_position_counter;
    localparam int unsigned WIDTH = 8;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             rot_a     = 1'b0;
    logic             rot_b     = 1'b0;
    logic             enable    = 1'b1;
    logic             clear     = 1'b0;
    logic             wrap_mode = 1'b0;
    logic [1:0]       step_sel  = 2'd0;
    logic [WIDTH-1:0] position;
    logic             rot_event;
    logic             rot_dir;
    logic             limit_hit;

    typedef struct {
        logic       dir;
        logic [7:0] pos;
        logic       lim;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors   = 0;
    int   checks   = 0;
    int   n_events = 0;
    int   cyc      = 0;

    rot_position_counter #(.WIDTH(WIDTH), .DEBOUNCE(4), .MAX_VAL(255)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ROT_A     (rot_a),
        .ROT_B     (rot_b),
        .enable    (enable),
        .clear     (clear),
        .wrap_mode (wrap_mode),
        .step_sel  (step_sel),
        .position  (position),
        .rot_event (rot_event),
        .rot_dir   (rot_dir),
        .limit_hit (limit_hit)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every event pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && rot_event) begin
            n_events++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got pos=%0d dir=%0d at cycle %0d, expected no event",
                         position, rot_dir, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ev_cycle", cyc, mon_e.cyc);
                chk("ev_dir", int'(rot_dir), int'(mon_e.dir));
                chk("ev_pos", int'(position), int'(mon_e.pos));
                chk("ev_lim", int'(limit_hit), int'(mon_e.lim));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic dir, input int pos, input logic lim);
        exp_t e;
        e.dir = dir;
        e.pos = 8'(pos);
        e.lim = lim;
        e.cyc = cyc + 9;
        exp_q.push_back(e);
    endtask

    // One full detent: 00 -> (10 up | 01 down) -> 11 -> 00, each held 20 cycles
    task automatic detent(input logic down, input int exp_pos, input logic exp_lim,
                          input logic clr_at_ev);
        rot_a = 1'b0; rot_b = 1'b0;
        tick(20);
        rot_a = ~down; rot_b = down;
        tick(20);
        rot_a = 1'b1; rot_b = 1'b1;
        push_exp(down, exp_pos, exp_lim);
        if (clr_at_ev) begin
            tick(8);
            clear = 1'b1;
            tick(1);
            clear = 1'b0;
            tick(11);
        end else begin
            tick(20);
        end
        rot_a = 1'b0; rot_b = 1'b0;
        tick(20);
    endtask

    initial begin
        int saved;
        tick(3);
        chk("rst_pos", int'(position), 0);
        chk("rst_event", int'(rot_event), 0);
        chk("rst_dir", int'(rot_dir), 0);
        chk("rst_lim", int'(limit_hit), 0);
        rst_n = 1'b1;
        tick(2);

        // Basic up/down and saturate at 0
        detent(1'b0, 1, 1'b0, 1'b0);
        step_sel = 2'd2;
        detent(1'b0, 5, 1'b0, 1'b0);
        detent(1'b1, 1, 1'b0, 1'b0);
        detent(1'b1, 0, 1'b1, 1'b0);
        detent(1'b1, 0, 1'b1, 1'b0);
        step_sel = 2'd0;
        detent(1'b0, 1, 1'b0, 1'b0);

        // Wrap downward and upward, then saturate at MAX_VAL
        wrap_mode = 1'b1;
        step_sel  = 2'd2;
        detent(1'b1, 253, 1'b1, 1'b0);
        step_sel = 2'd0;
        detent(1'b0, 254, 1'b0, 1'b0);
        step_sel = 2'd3;
        detent(1'b0, 6, 1'b1, 1'b0);
        detent(1'b1, 254, 1'b1, 1'b0);
        wrap_mode = 1'b0;
        detent(1'b0, 255, 1'b1, 1'b0);
        detent(1'b0, 255, 1'b1, 1'b0);

        // Short glitches must never be accepted
        saved = n_events;
        rot_a = 1'b1;
        tick(3);
        rot_a = 1'b0;
        tick(30);
        rot_a = 1'b1;
        tick(20);
        rot_b = 1'b1;
        tick(3);
        rot_b = 1'b0;
        tick(30);
        rot_a = 1'b0;
        tick(20);
        chk("glitch_events", n_events, saved);
        chk("glitch_pos", int'(position), 255);

        // Clear without event, build to 40, then clear on the event edge
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("clear_pos", int'(position), 0);
        for (int k = 1; k <= 5; k++) detent(1'b0, 8 * k, 1'b0, 1'b0);
        chk("pos_40", int'(position), 40);
        detent(1'b0, 0, 1'b0, 1'b1);
        chk("clear_ev_pos", int'(position), 0);

        // Disabled event still reported, position frozen
        step_sel = 2'd0;
        detent(1'b0, 1, 1'b0, 1'b0);
        enable = 1'b0;
        detent(1'b0, 1, 1'b0, 1'b0);
        enable = 1'b1;

        // Build to 77, then reset in the middle of debouncing 11
        step_sel = 2'd3;
        for (int k = 1; k <= 9; k++) detent(1'b0, 1 + 8 * k, 1'b0, 1'b0);
        step_sel = 2'd2;
        detent(1'b0, 77, 1'b0, 1'b0);
        chk("pos_77", int'(position), 77);
        step_sel = 2'd0;
        rot_a = 1'b1; rot_b = 1'b1;
        tick(3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pos", int'(position), 0);
        chk("async_rst_event", int'(rot_event), 0);
        chk("async_rst_dir", int'(rot_dir), 0);
        chk("async_rst_lim", int'(limit_hit), 0);
        tick(2);
        rst_n = 1'b1;
        push_exp(1'b0, 1, 1'b0);
        tick(20);
        rot_a = 1'b0; rot_b = 1'b0;
        tick(20);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(1);
        chk("pending_events", exp_q.size(), 0);
        chk("final_pos", int'(position), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
